// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control hub: stall patterns, exception codes, FSM states.
package pipe_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [31:0] ExcInterrupt = 32'h0000_0001;
  localparam logic [31:0] ExcSyscall   = 32'h0000_0008;
  localparam logic [31:0] ExcInvalid   = 32'h0000_000a;
  localparam logic [31:0] ExcOverflow  = 32'h0000_000c;
  localparam logic [31:0] ExcTrap      = 32'h0000_000d;
  localparam logic [31:0] ExcEret      = 32'h0000_000e;

  // Bit 0 = pc ... bit 5 = wb.
  localparam logic [5:0] StallNone = {6{NoStop}};
  localparam logic [5:0] StallIt   = 6'b000111;
  localparam logic [5:0] StallExe  = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;
  localparam logic [5:0] StallAll  = {6{Stop}};

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFreeze = 2'd1,
    StFlush  = 2'd2
  } state_e;

  function automatic logic [31:0] exc_target(input logic [31:0] exc_type,
                                             input logic [31:0] epc,
                                             input logic [31:0] vector);
    return (exc_type == ExcEret) ? epc : vector;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall statistics: saturating stall-cycle counter, run-length counter and sticky timeout flag.
module pipe_ctrl_stall_watchdog #(
  parameter int unsigned MaxStall = 16,
  parameter int unsigned CntW     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_active_i,
  input  logic            run_stall_i,
  output logic [CntW-1:0] stall_cycles_o,
  output logic            stall_timeout_o
);

  localparam int unsigned    RunW   = $clog2(MaxStall + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(MaxStall);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RunW-1:0] run_len_q, run_len_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_active_i && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + CntW'(1);
    end

    // Exception-driven stall cycles hold the run length rather than extend it.
    run_len_d = run_len_q;
    if (!stall_active_i) begin
      run_len_d = '0;
    end else if (run_stall_i && (run_len_q != RunMax)) begin
      run_len_d = run_len_q + RunW'(1);
    end

    timeout_d = timeout_q | (run_len_d == RunMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      run_len_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_len_q <= run_len_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_cycles_o  = cnt_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control hub: merges stage stall requests and sequences exception/eret redirection.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] ExcVector = 32'h0000_0020,
  parameter int unsigned MaxStall  = 16,
  parameter int unsigned CntW      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_if_i,
  input  logic            stallreq_it_i,
  input  logic            stallreq_exe_i,
  input  logic            stallreq_mem_i,
  input  logic [31:0]     mem_excepttype_i,
  input  logic [31:0]     cp0_epc_i,
  output logic [5:0]      stall_o,
  output logic            flush_o,
  output logic [31:0]     new_pc_o,
  output logic [CntW-1:0] stall_cycles_o,
  output logic            stall_timeout_o
);

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [5:0]  stall_raw;
  logic        run_stall;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    stall_raw = StallNone;
    run_stall = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_excepttype_i != '0) begin
          // Hold every slot so the excepting instruction never writes back.
          stall_raw = StallAll;
          state_d   = StFreeze;
          target_d  = exc_target(mem_excepttype_i, cp0_epc_i, ExcVector);
        end else begin
          if (stallreq_mem_i) begin
            stall_raw = StallMem;
          end else if (stallreq_exe_i) begin
            stall_raw = StallExe;
          end else if (stallreq_it_i || stallreq_if_i) begin
            stall_raw = StallIt;
          end
          run_stall = (stall_raw != StallNone);
        end
      end
      StFreeze: begin
        stall_raw = StallAll;
        state_d   = StFlush;
      end
      StFlush: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    flush_d  = (state_d == StFlush);
    new_pc_d = flush_d ? target_q : '0;
  end

  assign stall_o  = rst ? StallNone : stall_raw;
  assign flush_o  = flush_q;
  assign new_pc_o = new_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      target_q <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  pipe_ctrl_stall_watchdog #(
    .MaxStall(MaxStall),
    .CntW    (CntW)
  ) u_stall_watchdog (
    .clk            (clk),
    .rst            (rst),
    .stall_active_i (stall_o != StallNone),
    .run_stall_i    (run_stall),
    .stall_cycles_o (stall_cycles_o),
    .stall_timeout_o(stall_timeout_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stalls, exception/eret redirect, watchdog, reset.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0;
  logic        stallreq_it = 1'b0;
  logic        stallreq_exe = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic [31:0] mem_excepttype = '0;
  logic [31:0] cp0_epc = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_if_i   (stallreq_if),
    .stallreq_it_i   (stallreq_it),
    .stallreq_exe_i  (stallreq_exe),
    .stallreq_mem_i  (stallreq_mem),
    .mem_excepttype_i(mem_excepttype),
    .cp0_epc_i       (cp0_epc),
    .stall_o         (stall),
    .flush_o         (flush),
    .new_pc_o        (new_pc),
    .stall_cycles_o  (stall_cycles),
    .stall_timeout_o (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. Reset: stall forced low even with a request pending.
    stallreq_mem = 1'b1;
    tick();
    #1;
    check("rst_stall_forced", {26'd0, stall}, 32'h0);
    tick();
    rst = 1'b0;
    stallreq_mem = 1'b0;
    #1;
    check("idle_stall", {26'd0, stall}, 32'h0);
    check("idle_flush", {31'd0, flush}, 32'h0);
    check("idle_new_pc", new_pc, 32'h0);
    check("idle_cycles", stall_cycles, 32'd0);
    check("idle_timeout", {31'd0, stall_timeout}, 32'h0);
    tick();
    check("idle_cycles_after", stall_cycles, 32'd0);

    // 2. exe + it for 3 cycles -> exe pattern wins.
    stallreq_exe = 1'b1;
    stallreq_it  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("exe_it_stall", {26'd0, stall}, 32'h0f);
      tick();
    end
    stallreq_exe = 1'b0;
    #1;
    check("it_only_stall", {26'd0, stall}, 32'h07);
    stallreq_it = 1'b0;
    stallreq_if = 1'b1;
    #1;
    check("if_only_stall", {26'd0, stall}, 32'h07);
    stallreq_if = 1'b0;
    #1;
    check("exe_cycles", stall_cycles, 32'd3);
    check("exe_timeout", {31'd0, stall_timeout}, 32'h0);
    tick();

    // 3. Syscall exception -> vector 0x20.
    mem_excepttype = 32'h8;
    #1;
    check("exc_n_stall", {26'd0, stall}, 32'h3f);
    check("exc_n_flush", {31'd0, flush}, 32'h0);
    tick();
    mem_excepttype = 32'h0;
    #1;
    check("exc_n1_stall", {26'd0, stall}, 32'h3f);
    check("exc_n1_flush", {31'd0, flush}, 32'h0);
    check("exc_n1_new_pc", new_pc, 32'h0);
    tick();
    check("exc_n2_flush", {31'd0, flush}, 32'h1);
    check("exc_n2_new_pc", new_pc, 32'h20);
    check("exc_n2_stall", {26'd0, stall}, 32'h0);
    tick();
    check("exc_n3_flush", {31'd0, flush}, 32'h0);
    check("exc_n3_stall", {26'd0, stall}, 32'h0);
    check("exc_n3_new_pc", new_pc, 32'h0);
    check("exc_cycles", stall_cycles, 32'd5);

    // 4. eret with stallreq_mem; second exception in FREEZE dropped.
    mem_excepttype = 32'he;
    cp0_epc = 32'h0000_1234;
    stallreq_mem = 1'b1;
    #1;
    check("eret_prio_stall", {26'd0, stall}, 32'h3f);
    tick();
    mem_excepttype = 32'h8;
    cp0_epc = 32'h0000_5678;
    #1;
    check("eret_freeze_stall", {26'd0, stall}, 32'h3f);
    check("eret_freeze_flush", {31'd0, flush}, 32'h0);
    tick();
    mem_excepttype = 32'h0;
    stallreq_mem = 1'b0;
    #1;
    check("eret_flush", {31'd0, flush}, 32'h1);
    check("eret_new_pc", new_pc, 32'h1234);
    check("eret_flush_stall", {26'd0, stall}, 32'h0);
    tick();
    check("eret_after_flush", {31'd0, flush}, 32'h0);
    tick();
    check("eret_single_pulse", {31'd0, flush}, 32'h0);
    check("eret_cycles", stall_cycles, 32'd7);

    // 5. Watchdog: 16 consecutive mem stalls.
    stallreq_mem = 1'b1;
    #1;
    check("wd_stall", {26'd0, stall}, 32'h1f);
    for (int i = 0; i < 15; i++) tick();
    check("wd_timeout_15", {31'd0, stall_timeout}, 32'h0);
    tick();
    check("wd_timeout_16", {31'd0, stall_timeout}, 32'h1);
    stallreq_mem = 1'b0;
    tick();
    check("wd_sticky", {31'd0, stall_timeout}, 32'h1);
    check("wd_cycles", stall_cycles, 32'd23);

    // 6. Reset during FREEZE.
    mem_excepttype = 32'hc;
    tick();
    mem_excepttype = 32'h0;
    rst = 1'b1;
    #1;
    check("rstf_stall_forced", {26'd0, stall}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("rstf_flush", {31'd0, flush}, 32'h0);
    check("rstf_new_pc", new_pc, 32'h0);
    check("rstf_cycles", stall_cycles, 32'd0);
    check("rstf_timeout", {31'd0, stall_timeout}, 32'h0);
    check("rstf_stall", {26'd0, stall}, 32'h0);
    stallreq_mem = 1'b1;
    #1;
    check("rstf_run_stall", {26'd0, stall}, 32'h1f);
    tick();
    stallreq_mem = 1'b0;
    check("rstf_no_flush_1", {31'd0, flush}, 32'h0);
    tick();
    check("rstf_no_flush_2", {31'd0, flush}, 32'h0);
    check("rstf_cycles_after", stall_cycles, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control hub for the 6-slot MIPS32 pipeline (pc, if, it, exe, mem, wb). It drives the `stall[5:0]` vector and the `flush`/`new_pc` pair that every inter-stage register, including it_exe, consumes. It merges per-stage stall requests, sequences exception/eret redirection through a small FSM, and keeps stall statistics plus a stall watchdog.

Parameters:
EXC_VECTOR, 32'h0000_0020, handler entry address for all non-eret exceptions.
MAX_STALL, 16, consecutive stall cycles before `stall_timeout` sets.
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  clock
rst  in  1  reset; rst synchronous, active-high; clock clk
stallreq_if  in  1  fetch stage requests a stall
stallreq_it  in  1  issue/decode stage requests a stall
stallreq_exe  in  1  execute stage requests a stall (multicycle op)
stallreq_mem  in  1  memory stage requests a stall
mem_excepttype  in  32  final exception type from mem stage; 0 = none
cp0_epc  in  32  current EPC from CP0
stall  out  6  per-slot hold, bit0 = pc ... bit5 = wb; 1 = Stop
flush  out  1  clear all pipeline registers; pc loads `new_pc`
new_pc  out  32  redirect target, valid only while `flush` = 1
stall_cycles  out  CNT_W  count of cycles with `stall` != 0; saturating
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst = 1 at posedge): state = RUN, flush = 0, new_pc = 0, stall_cycles = 0, stall_timeout = 0, internal run-length counter = 0. The `stall` output is combinational but forced to 6'b000000 while rst = 1.
- FSM states: RUN, FREEZE, FLUSH.
- RUN, mem_excepttype == 0:
  - Combinational stall, highest priority first: stallreq_mem -> 6'b011111; stallreq_exe -> 6'b001111; stallreq_it -> 6'b000111; stallreq_if -> 6'b000111; else 6'b000000.
  - flush = 0.
- RUN, mem_excepttype != 0:
  - Same cycle: stall = 6'b111111, so all slots hold and no wb of the excepting instruction occurs. Stall requests are ignored.
  - Next state = FREEZE.
  - Latch target: 32'h0000_000e (eret) -> cp0_epc; any other nonzero value -> EXC_VECTOR.
- FREEZE (1 cycle): stall = 6'b111111, flush = 0, next state = FLUSH.
  - The target is registered so that `new_pc` is stable from the first FLUSH cycle.
- FLUSH (1 cycle): flush = 1, stall = 6'b000000, new_pc = latched target; next state = RUN.
  - mem_excepttype and all stall requests are ignored in FREEZE and FLUSH.
  - flush is a registered output: high exactly one cycle, two cycles after the exception is seen.
- new_pc is 0 in every state except FLUSH; it holds the target only during FLUSH.
- stall_cycles: increments at posedge when `stall` != 0 (includes FREEZE and the exception cycle). Saturates at all-ones; no wrap.
- Watchdog:
  - The run-length counter increments while a RUN-state stall request keeps `stall` != 0, and clears on any cycle with `stall` == 0.
  - When the counter reaches MAX_STALL, stall_timeout sets and stays set until rst.
  - The counter saturates at MAX_STALL.
- Simultaneous events:
  - An exception in the same cycle as stall requests: the exception wins.
  - An exception arriving in FREEZE or FLUSH is dropped. The mem stage re-presents it after refill if it is still valid.
- Reset mid-sequence (FREEZE/FLUSH): return to RUN immediately, no flush pulse.

Decomposition:
- Shared defines file, extended with:
  - Stop/NoStop.
  - Exception codes (interrupt 0x1, syscall 0x8, invalid 0xa, trap 0xd, overflow 0xc, eret 0xe).
  - The stall pattern constants STALL_MEM/EXE/IT/NONE/ALL.
  - FSM state encodings.
- One natural sub-module, `stall_watchdog`, containing the saturating stall_cycles counter, the run-length counter and the sticky flag. The FSM and priority encoder stay in pipe_ctrl.

Test Plan:
1. Reset, then idle with all inputs 0 -> stall = 000000, flush = 0, new_pc = 0, stall_cycles = 0.
2. stallreq_exe = 1 for 3 cycles with stallreq_it = 1 concurrently -> stall = 001111 each cycle, stall_cycles = 3, stall_timeout = 0.
3. mem_excepttype = 32'h8 for 1 cycle in RUN:
   - Cycle N and N+1: stall = 111111.
   - Cycle N+2: flush = 1, new_pc = 32'h20.
   - Cycle N+3: flush = 0, stall = 000000.
4. mem_excepttype = 32'he with cp0_epc = 32'h0000_1234, while stallreq_mem = 1:
   - Exception takes priority.
   - Flush cycle: new_pc = 32'h1234.
   - A second excepttype = 8 applied during FREEZE is ignored (single flush pulse).
5. stallreq_mem held for 16 cycles -> stall_timeout rises at the 16th counted posedge and stays 1 after stallreq_mem drops. Only rst clears it.
6. Assert rst during FREEZE -> next cycle state RUN, flush never asserts, stall_cycles = 0, stall_timeout = 0.
